// File: rtl/adc_sampler.sv
// adc_sampler: periodically triggers an SPI-style 12-bit ADC conversion, shifts the
// 6-bit config word out on ADC_DIN while shifting the result in on ADC_DOUT, and
// presents the last complete sample on ADC_value with a one-cycle valid strobe.
module adc_sampler #(
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned CONV_CYCLES   = 80,
    parameter int unsigned SAMPLE_PERIOD = 2500,
    parameter logic [5:0]  CONFIG        = 6'b100010
) (
    input  logic        CLOCK_50,
    input  logic        KEY0,
    input  logic        enable,
    input  logic        ADC_DOUT,
    output logic        ADC_CONVST,
    output logic        ADC_SCLK,
    output logic        ADC_DIN,
    output logic [11:0] ADC_value,
    output logic        valid,
    output logic        overrun
);

    typedef enum logic [2:0] {StIdle, StConvst, StWait, StShift, StDone} state_e;

    localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    // cnt holds 0..1 in CONVST and 0..CONV_CYCLES-1 in WAIT
    localparam int unsigned CW = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // 12 SCLK periods = 24 half-periods, numbered 0..23; odd halves are SCLK high
    localparam logic [4:0]  LastHalf = 5'd23;

    state_e        state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    half_q, half_d;
    logic [11:0]   shreg_q, shreg_d;
    logic [11:0]   value_q, value_d;
    logic          overrun_q, overrun_d;
    logic          tick;
    logic [3:0]    bit_idx;
    logic [2:0]    cfg_sel;

    // Sample-period counter: free-runs while enabled, parked at 0 otherwise so a
    // re-enable starts a conversion on the very next edge.
    always_comb begin
        period_d = period_q;
        if (!enable) begin
            period_d = '0;
        end else if (period_q == PW'(SAMPLE_PERIOD - 1)) begin
            period_d = '0;
        end else begin
            period_d = period_q + 1'b1;
        end
    end

    assign tick = enable && (period_q == '0);

    // Ticks that arrive while a conversion is in flight are dropped and remembered.
    always_comb begin
        overrun_d = overrun_q | (tick && (state_q != StIdle));
    end

    // Capture ADC_DOUT on the first cycle of each SCLK high half-period.
    always_comb begin
        shreg_d = shreg_q;
        if ((state_q == StShift) && half_q[0] && (div_q == '0)) begin
            shreg_d = {shreg_q[10:0], ADC_DOUT};
        end
    end

    // Conversion sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        half_d  = half_q;
        value_d = value_q;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StConvst;
                    cnt_d   = '0;
                end
            end
            StConvst: begin
                if (cnt_q == CW'(1)) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == CW'(CONV_CYCLES - 1)) begin
                    state_d = StShift;
                    div_d   = '0;
                    half_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (div_q == DW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (half_q == LastHalf) begin
                        state_d = StDone;
                        // shreg_d so the final bit is included even when CLK_DIV == 1
                        value_d = shreg_d;
                    end else begin
                        half_d = half_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q   <= StIdle;
            period_q  <= '0;
            cnt_q     <= '0;
            div_q     <= '0;
            half_q    <= '0;
            shreg_q   <= '0;
            value_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            half_q    <= half_d;
            shreg_q   <= shreg_d;
            value_q   <= value_d;
            overrun_q <= overrun_d;
        end
    end

    // ADC pin decode; DIN walks CONFIG MSB-first for the first six SCLK periods.
    always_comb begin
        bit_idx    = half_q[4:1];
        cfg_sel    = (bit_idx < 4'd6) ? 3'(4'd5 - bit_idx) : 3'd0;
        ADC_CONVST = (state_q == StConvst);
        ADC_SCLK   = (state_q == StShift) && half_q[0];
        ADC_DIN    = (state_q == StShift) && (bit_idx < 4'd6) && CONFIG[cfg_sel];
        valid      = (state_q == StDone);
    end

    assign ADC_value = value_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: instance A uses default parameters; instance B uses a 100-cycle
// sample period so that a tick lands mid-conversion. Each instance has a small
// behavioural ADC that returns a chosen word MSB-first and a monitor that records
// CONVST/SCLK activity for the main sequence to check.
module tb_adc_sampler;

    localparam int DIV      = 2;
    localparam int CONV     = 80;
    localparam int A_PERIOD = 2500;
    localparam int B_PERIOD = 100;
    localparam logic [5:0]  CFG     = 6'b100010;
    localparam int          LAT     = 2 + CONV + 24 * DIV;   // CONVST rise to valid
    localparam int          BUSY    = LAT + 1;               // CONVST rise to idle
    localparam logic [11:0] DIN_EXP = {CFG, 6'b000000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A (defaults)
    logic a_key0 = 1'b0, a_en = 1'b0, a_dout = 1'b0;
    logic a_convst, a_sclk, a_din, a_valid, a_overrun;
    logic [11:0] a_value;

    adc_sampler dut_a (
        .CLOCK_50  (clk),
        .KEY0      (a_key0),
        .enable    (a_en),
        .ADC_DOUT  (a_dout),
        .ADC_CONVST(a_convst),
        .ADC_SCLK  (a_sclk),
        .ADC_DIN   (a_din),
        .ADC_value (a_value),
        .valid     (a_valid),
        .overrun   (a_overrun)
    );

    // Instance B (short sample period)
    logic b_key0 = 1'b0, b_en = 1'b0, b_dout = 1'b0;
    logic b_convst, b_sclk, b_din, b_valid, b_overrun;
    logic [11:0] b_value;

    adc_sampler #(.SAMPLE_PERIOD(B_PERIOD)) dut_b (
        .CLOCK_50  (clk),
        .KEY0      (b_key0),
        .enable    (b_en),
        .ADC_DOUT  (b_dout),
        .ADC_CONVST(b_convst),
        .ADC_SCLK  (b_sclk),
        .ADC_DIN   (b_din),
        .ADC_value (b_value),
        .valid     (b_valid),
        .overrun   (b_overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // ADC model + monitor for A
    logic [11:0] a_word = 12'h000;
    int a_idx = 12, a_rise_cyc = 0, a_prev_rise_cyc = 0, a_rise_count = 0;
    int a_sclk_rises = 0, a_conv_len = 0;
    logic [11:0] a_din_bits = 12'h000;
    logic a_convst_prev = 1'b0, a_sclk_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        if (a_convst && !a_convst_prev) begin
            a_prev_rise_cyc = a_rise_cyc;
            a_rise_cyc      = cyc;
            a_rise_count++;
            a_sclk_rises = 0;
            a_din_bits   = 12'h000;
            a_conv_len   = 0;
        end
        if (a_convst) a_conv_len++;
        else if (a_convst_prev) check("convst_width", a_conv_len, 2);
        if (a_sclk && !a_sclk_prev) begin
            a_sclk_rises++;
            a_din_bits = {a_din_bits[10:0], a_din};
        end
        if (a_convst) a_idx = 0;
        else if (!a_sclk && a_sclk_prev) a_idx++;
        a_dout = (a_idx < 12) ? a_word[11 - a_idx] : 1'($urandom_range(0, 1));
        a_convst_prev = a_convst;
        a_sclk_prev   = a_sclk;
    end

    // ADC model + monitor for B
    logic [11:0] b_word = 12'h000;
    int b_idx = 12, b_rise_cyc = 0, b_rise_count = 0;
    logic b_convst_prev = 1'b0, b_sclk_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        if (b_convst && !b_convst_prev) begin
            b_rise_cyc = cyc;
            b_rise_count++;
        end
        if (b_convst) b_idx = 0;
        else if (!b_sclk && b_sclk_prev) b_idx++;
        b_dout = (b_idx < 12) ? b_word[11 - b_idx] : 1'($urandom_range(0, 1));
        b_convst_prev = b_convst;
        b_sclk_prev   = b_sclk;
    end

    // Reference schedule for B: ticks every B_PERIOD cycles (offset from the first
    // start); a tick is taken only if the previous conversion is back in idle on the
    // tick cycle, i.e. one cycle before the would-be start.
    function automatic int model_start(input int k);
        int free = -1;
        int n = 0;
        for (int t = 0; t < 100000; t += B_PERIOD) begin
            if (t - 1 >= free) begin
                if (n == k) return t;
                n++;
                free = t + BUSY;
            end
        end
        return -1;
    endfunction

    function automatic int model_overrun(input int off);
        int free = -1;
        for (int t = 0; t <= off; t += B_PERIOD) begin
            if (t - 1 >= free) free = t + BUSY;
            else return 1;
        end
        return 0;
    endfunction

    task automatic wait_for(input string name, input int sel, input int target,
                            input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            case (sel)
                0: ok = (a_valid === 1'b1);
                1: ok = (b_valid === 1'b1);
                2: ok = (a_rise_count >= target);
                3: ok = (b_rise_count >= target);
                4: ok = (a_sclk_rises >= target);
                default: ok = 1'b0;
            endcase
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
    endtask

    typedef struct {
        logic [11:0] word;
        logic [11:0] exp_value;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit ok;
        int rel, c0, cnt, en_cyc;
        logic [11:0] cur;

        vecs[0] = '{12'hABC, 12'hABC};
        vecs[1] = '{12'h000, 12'h000};
        vecs[2] = '{12'hFFF, 12'hFFF};
        vecs[3] = '{12'h555, 12'h555};
        vecs[4] = '{12'hA5A, 12'hA5A};

        // Reset held with enable high and random DOUT: nothing may move
        a_en = 1'b1;
        b_en = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("reset_outputs_a", int'({a_convst, a_sclk, a_din, a_valid, a_overrun, a_value}), 0);
        check("reset_outputs_b", int'({b_convst, b_sclk, b_din, b_valid, b_overrun, b_value}), 0);
        check("reset_no_convst", a_rise_count, 0);
        check("reset_no_sclk", a_sclk_rises, 0);

        // Defaults: table of ADC words, one conversion each
        a_word = vecs[0].word;
        a_key0 = 1'b1;
        rel    = cyc;
        for (int i = 0; i < 5; i++) begin
            wait_for("a_convst", 2, i + 1, A_PERIOD + 10, ok);
            if (i == 0) begin
                check("first_convst_after_release", a_rise_cyc, rel + 1);
            end else begin
                check("convst_period", a_rise_cyc - a_prev_rise_cyc, A_PERIOD);
                check("value_hold", int'(a_value), int'(vecs[i - 1].exp_value));
            end
            wait_for("a_valid", 0, 0, LAT + 10, ok);
            check("value", int'(a_value), int'(vecs[i].exp_value));
            check("latency", cyc - a_rise_cyc, LAT);
            check("sclk_rises", a_sclk_rises, 12);
            check("din_bits", int'(a_din_bits), int'(DIN_EXP));
            check("overrun_clear", int'(a_overrun), 0);
            if (i < 4) a_word = vecs[i + 1].word;
            @(negedge clk);
            #1;
            check("valid_one_cycle", int'(a_valid), 0);
        end

        // Drop enable during WAIT: conversion finishes, then nothing starts
        a_word = 12'h3C7;
        wait_for("a_convst_dis", 2, 6, A_PERIOD + 10, ok);
        repeat (10) @(negedge clk);
        #1;
        a_en = 1'b0;
        wait_for("a_valid_dis", 0, 0, LAT + 10, ok);
        check("disabled_value", int'(a_value), 12'h3C7);
        check("disabled_latency", cyc - a_rise_cyc, LAT);
        cnt = a_rise_count;
        repeat (10000) @(negedge clk);
        #1;
        check("no_convst_while_disabled", a_rise_count, cnt);
        a_word = 12'hFFF;
        a_en   = 1'b1;
        en_cyc = cyc;
        wait_for("a_convst_reen", 2, cnt + 1, 5, ok);
        check("reenable_convst", a_rise_cyc, en_cyc + 1);

        // Reset pulse after the 5th SCLK rise discards the partial word
        wait_for("a_sclk5", 4, 5, LAT + 10, ok);
        #2;
        a_key0 = 1'b0;
        #1;
        check("midshift_reset_outputs",
              int'({a_convst, a_sclk, a_din, a_valid, a_overrun, a_value}), 0);
        repeat (3) @(negedge clk);
        #1;
        a_word = 12'h5A3;
        cnt    = a_rise_count;
        a_key0 = 1'b1;
        rel    = cyc;
        wait_for("a_convst_rst", 2, cnt + 1, 5, ok);
        check("restart_after_reset", a_rise_cyc, rel + 1);
        check("value_zero_after_reset", int'(a_value), 0);
        wait_for("a_valid_rst", 0, 0, LAT + 10, ok);
        check("value_after_reset", int'(a_value), 12'h5A3);
        check("sclk_rises_after_reset", a_sclk_rises, 12);

        // Instance B: random words against the reference tick schedule
        b_word = 12'($urandom);
        @(negedge clk);
        #1;
        b_key0 = 1'b1;
        rel    = cyc;
        c0     = 0;
        for (int k = 0; k < 8; k++) begin
            wait_for("b_convst", 3, k + 1, 4 * B_PERIOD, ok);
            if (k == 0) begin
                check("b_first_start", b_rise_cyc, rel + 1);
                c0 = b_rise_cyc;
            end else begin
                check("b_start_offset", b_rise_cyc - c0, model_start(k));
            end
            check("b_overrun_at_start", int'(b_overrun), model_overrun(b_rise_cyc - c0));
            cur = b_word;
            wait_for("b_valid", 1, 0, LAT + 10, ok);
            check("b_value", int'(b_value), int'(cur));
            check("b_latency", cyc - b_rise_cyc, LAT);
            check("b_overrun_at_valid", int'(b_overrun), model_overrun(cyc - c0));
            b_word = 12'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_sampler.md
ADC_SAMPLER -- requirements
Module: adc_sampler

Interface
REQ-001 Parameter CLK_DIV, default 2: SCLK half-period in CLOCK_50 cycles, legal range >=1.
REQ-002 Parameter CONV_CYCLES, default 80: conversion wait in cycles, 1.6 us at 50 MHz.
REQ-003 Parameter SAMPLE_PERIOD, default 2500: cycles between conversion starts, 20 kHz at 50 MHz.
REQ-004 Parameter CONFIG, default 6'b100010: ADC config word (single-ended ch0, unipolar, no sleep), shifted out MSB first.
REQ-005 CLOCK_50  input  1  system clock; all logic on rising edge.
REQ-006 KEY0  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  high permits new conversion starts.
REQ-008 ADC_DOUT  input  1  serial data from ADC, MSB first.
REQ-009 ADC_CONVST  output  1  conversion start pulse to ADC.
REQ-010 ADC_SCLK  output  1  serial clock to ADC.
REQ-011 ADC_DIN  output  1  serial config data to ADC.
REQ-012 ADC_value  output  12  last completed sample; feeds the max-tracking comparator.
REQ-013 valid  output  1  one-cycle pulse when ADC_value updates.
REQ-014 overrun  output  1  sticky flag: a start tick was dropped.

Function
REQ-015 Period counter SHALL run 0..SAMPLE_PERIOD-1 and wrap while enable=1; it SHALL hold at 0 while enable=0.
REQ-016 A start tick SHALL occur on every cycle where counter==0 and enable==1.
REQ-017 FSM states SHALL be IDLE, CONVST, WAIT, SHIFT, DONE.
REQ-018 IDLE->CONVST on a tick; ADC_CONVST SHALL be high for exactly 2 cycles (CONVST state), low in every other state.
REQ-019 CONVST->WAIT after 2 cycles; WAIT lasts exactly CONV_CYCLES cycles, then ->SHIFT.
REQ-020 SHIFT SHALL generate exactly 12 SCLK periods: SCLK low CLK_DIV cycles, then high CLK_DIV cycles; SCLK low outside SHIFT.
REQ-021 ADC_DIN SHALL present CONFIG[5] from SHIFT entry; it SHALL advance one bit on each SCLK falling edge for bits 5..0, then drive 0 for the remaining periods and outside SHIFT.
REQ-022 ADC_DOUT SHALL be sampled on the cycle SCLK rises, into a 12-bit shift register, MSB first.
REQ-023 After the 12th high half-period, FSM->DONE: ADC_value <= shift register, valid=1 for that one cycle, then ->IDLE.
REQ-024 Latency SHALL be exactly 2+CONV_CYCLES+24*CLK_DIV cycles from the first ADC_CONVST-high cycle to the valid cycle (130 with defaults).
REQ-025 A tick while state!=IDLE SHALL be dropped (no queuing) and SHALL set overrun; overrun stays 1 until reset.
REQ-026 A tick coinciding with DONE SHALL be dropped and SHALL set overrun.
REQ-027 Deasserting enable mid-conversion SHALL NOT abort it; the conversion completes with valid, and no further conversions start.
REQ-028 ADC_value SHALL hold between valid pulses; no other path modifies it.

Reset
REQ-029 KEY0=0 SHALL immediately force: state IDLE, counter 0, ADC_CONVST=0, ADC_SCLK=0, ADC_DIN=0, ADC_value=12'h000, valid=0, overrun=0, shift register 0.
REQ-030 Reset mid-conversion SHALL discard the partial sample; ADC_value SHALL stay 0 until the next complete conversion.
REQ-031 With enable=1 at release, the first ADC_CONVST rise SHALL occur on the first clock edge after KEY0 rises.

Verification
REQ-032 Reset check: hold KEY0=0 with random ADC_DOUT -> all outputs 0, no SCLK or CONVST activity.
REQ-033 Defaults, ADC model returns 12'hABC -> ADC_value=12'hABC, valid high exactly 1 cycle, 130 cycles after CONVST rise, next CONVST 2500 cycles after previous.
REQ-034 DIN check -> bits 1,0,0,0,1,0 sampled on SCLK rises 1..6, then 0 on rises 7..12; exactly 12 SCLK rises per conversion.
REQ-035 SAMPLE_PERIOD=100 -> tick at 100 dropped, overrun=1, conversions start at cycles 0, 200, 400.
REQ-036 enable=0 during WAIT -> that conversion completes with valid; no further CONVST for 10000 cycles; re-enable -> CONVST on the next edge.
REQ-037 KEY0 pulsed low during SHIFT (after rise 5) -> outputs cleared immediately; next sample returns the model value, not a partial word.
